// File: rtl/ysyx_040750_data_ld.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_040750_data_ld
// Brief    : Load-data aligner. Extracts a byte/half/word/dword at a byte
//            offset of an 8-byte read beat and sign/zero-extends it.
//            YSYX_040750_LD_MISALIGN_EN enables two-beat line-crossing loads;
//            without it a crossing load returns an error.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_040750_data_ld (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_req_valid,
    output logic        O_req_ready,
    input  logic [2:0]  I_addr_off,
    input  logic [1:0]  I_size,
    input  logic        I_unsigned,
    input  logic [4:0]  I_rd,
    input  logic        I_rdata_valid,
    input  logic [63:0] I_rdata,
    output logic        O_ld_valid,
    input  logic        I_ld_ready,
    output logic [63:0] O_ld_data,
    output logic [4:0]  O_ld_rd,
    output logic        O_ld_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT0 = 2'd1,
        S_WAIT1 = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic [63:0] r_data;
    logic        r_err;

    logic [3:0]  w_bytes;
    logic        w_cross;
    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic [63:0] w_ext;

    assign w_bytes = 4'd1 << r_size;
    assign w_cross = ({1'b0, r_off} + w_bytes) > 4'd8;
    assign w_shamt = {r_off, 3'b000};

`ifdef YSYX_040750_LD_MISALIGN_EN
    logic [63:0] r_beat0;

    // Second beat supplies the upper bytes of the {beat1, beat0} window.
    assign w_shifted = (r_state == S_WAIT1)
                     ? ((r_beat0 >> w_shamt) | (I_rdata << (7'd64 - {1'b0, w_shamt})))
                     : (I_rdata >> w_shamt);
`else
    assign w_shifted = I_rdata >> w_shamt;
`endif

    always_comb begin
        w_ext = w_shifted;
        case (r_size)
            2'd0:    w_ext = r_unsigned ? {56'd0, w_shifted[7:0]}
                                        : {{56{w_shifted[7]}}, w_shifted[7:0]};
            2'd1:    w_ext = r_unsigned ? {48'd0, w_shifted[15:0]}
                                        : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_ext = r_unsigned ? {32'd0, w_shifted[31:0]}
                                        : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: w_ext = w_shifted;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (I_req_valid) w_next = S_WAIT0;
            S_WAIT0: begin
                if (I_rdata_valid) begin
`ifdef YSYX_040750_LD_MISALIGN_EN
                    w_next = w_cross ? S_WAIT1 : S_OUT;
`else
                    w_next = S_OUT;
`endif
                end
            end
            S_WAIT1: if (I_rdata_valid) w_next = S_OUT;
            S_OUT:   if (I_ld_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_state    <= S_IDLE;
            r_off      <= 3'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_rd       <= 5'd0;
            r_data     <= 64'd0;
            r_err      <= 1'b0;
`ifdef YSYX_040750_LD_MISALIGN_EN
            r_beat0    <= 64'd0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (I_req_valid) begin
                        r_off      <= I_addr_off;
                        r_size     <= I_size;
                        r_unsigned <= I_unsigned;
                        r_rd       <= I_rd;
                        r_err      <= 1'b0;
                    end
                end
                S_WAIT0: begin
                    if (I_rdata_valid) begin
                        if (w_cross) begin
`ifdef YSYX_040750_LD_MISALIGN_EN
                            r_beat0 <= I_rdata;
`else
                            r_data  <= 64'd0;
                            r_err   <= 1'b1;
`endif
                        end else begin
                            r_data <= w_ext;
                            r_err  <= 1'b0;
                        end
                    end
                end
                S_WAIT1: begin
                    if (I_rdata_valid) begin
                        r_data <= w_ext;
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_req_ready = (r_state == S_IDLE);
    assign O_ld_valid  = (r_state == S_OUT);
    assign O_ld_data   = r_data;
    assign O_ld_rd     = r_rd;
    assign O_ld_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_040750_data_ld.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_040750_data_ld
// Brief    : Directed self-checking bench for the load-data aligner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_040750_data_ld;

    logic        I_sys_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_req_valid = 1'b0;
    logic        O_req_ready;
    logic [2:0]  I_addr_off = 3'd0;
    logic [1:0]  I_size = 2'd0;
    logic        I_unsigned = 1'b0;
    logic [4:0]  I_rd = 5'd0;
    logic        I_rdata_valid = 1'b0;
    logic [63:0] I_rdata = 64'd0;
    logic        O_ld_valid;
    logic        I_ld_ready = 1'b0;
    logic [63:0] O_ld_data;
    logic [4:0]  O_ld_rd;
    logic        O_ld_err;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] C_BEAT0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C_BEAT1 = 64'h1122334455667788;

    ysyx_040750_data_ld dut (
        .I_sys_clk    (I_sys_clk),
        .I_rst        (I_rst),
        .I_req_valid  (I_req_valid),
        .O_req_ready  (O_req_ready),
        .I_addr_off   (I_addr_off),
        .I_size       (I_size),
        .I_unsigned   (I_unsigned),
        .I_rd         (I_rd),
        .I_rdata_valid(I_rdata_valid),
        .I_rdata      (I_rdata),
        .O_ld_valid   (O_ld_valid),
        .I_ld_ready   (I_ld_ready),
        .O_ld_data    (O_ld_data),
        .O_ld_rd      (O_ld_rd),
        .O_ld_err     (O_ld_err)
    );

    always #5 I_sys_clk = ~I_sys_clk;

    task automatic tick();
        @(posedge I_sys_clk);
        #1;
    endtask

    task automatic issue_req(input logic [2:0] off, input logic [1:0] size,
                             input logic uns, input logic [4:0] rd);
        I_req_valid = 1'b1;
        I_addr_off  = off;
        I_size      = size;
        I_unsigned  = uns;
        I_rd        = rd;
        tick();
        I_req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data);
        I_rdata_valid = 1'b1;
        I_rdata       = data;
        tick();
        I_rdata_valid = 1'b0;
    endtask

    task automatic consume();
        I_ld_ready = 1'b1;
        tick();
        I_ld_ready = 1'b0;
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        tick();
        tick();
        I_rst = 1'b0;
        checks++;
        if (O_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", O_req_ready); end
        checks++;
        if (O_ld_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", O_ld_valid); end
        checks++;
        if (O_ld_data !== 64'd0 || O_ld_rd !== 5'd0 || O_ld_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h rd=%0d err=%b expected 0/0/0", O_ld_data, O_ld_rd, O_ld_err);
        end
    endtask

    task automatic test_extract();
        logic [2:0]  off;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] exp;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin off = 3'd3; size = 2'd0; uns = 1'b0; exp = 64'hFFFFFFFFFFFFFF89; end
                1: begin off = 3'd3; size = 2'd0; uns = 1'b1; exp = 64'h0000000000000089; end
                2: begin off = 3'd4; size = 2'd2; uns = 1'b0; exp = 64'h0000000001234567; end
                3: begin off = 3'd6; size = 2'd1; uns = 1'b1; exp = 64'h0000000000000123; end
                4: begin off = 3'd2; size = 2'd1; uns = 1'b0; exp = 64'hFFFFFFFFFFFF89AB; end
                default: begin off = 3'd0; size = 2'd2; uns = 1'b1; exp = 64'h0000000089ABCDEF; end
            endcase
            issue_req(off, size, uns, 5'(i + 3));
            checks++;
            if (O_req_ready !== 1'b0) begin errors++; $display("FAIL ext%0d_busy: got ready=%b expected 0", i, O_req_ready); end
            // Idle cycles in WAIT0 must not advance the FSM.
            tick();
            tick();
            checks++;
            if (O_ld_valid !== 1'b0) begin errors++; $display("FAIL ext%0d_wait: got valid=%b expected 0", i, O_ld_valid); end
            send_beat(C_BEAT0);
            checks++;
            if (O_ld_valid !== 1'b1 || O_ld_data !== exp || O_ld_rd !== 5'(i + 3) || O_ld_err !== 1'b0) begin
                errors++;
                $display("FAIL ext%0d_result: got v=%b data=%h rd=%0d err=%b expected v=1 data=%h rd=%0d err=0",
                         i, O_ld_valid, O_ld_data, O_ld_rd, O_ld_err, exp, i + 3);
            end
            consume();
            checks++;
            if (O_ld_valid !== 1'b0 || O_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL ext%0d_done: got valid=%b ready=%b expected 0/1", i, O_ld_valid, O_req_ready);
            end
        end
    endtask

    task automatic test_ignore_idle_beat();
        send_beat(C_BEAT1);
        tick();
        checks++;
        if (O_ld_valid !== 1'b0 || O_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_beat: got valid=%b ready=%b expected 0/1", O_ld_valid, O_req_ready);
        end
    endtask

    task automatic test_crossing();
        logic [1:0]  size;
        logic [2:0]  off;
        logic [63:0] exp;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin off = 3'd6; size = 2'd2; exp = 64'h0000000077880123; end
            else        begin off = 3'd1; size = 2'd3; exp = 64'h880123456789ABCD; end
            issue_req(off, size, 1'b0, 5'd17);
            send_beat(C_BEAT0);
`ifdef YSYX_040750_LD_MISALIGN_EN
            checks++;
            if (O_ld_valid !== 1'b0) begin errors++; $display("FAIL cross%0d_early: got valid=%b expected 0", i, O_ld_valid); end
            send_beat(C_BEAT1);
            checks++;
            if (O_ld_valid !== 1'b1 || O_ld_data !== exp || O_ld_err !== 1'b0) begin
                errors++;
                $display("FAIL cross%0d_result: got v=%b data=%h err=%b expected v=1 data=%h err=0",
                         i, O_ld_valid, O_ld_data, O_ld_err, exp);
            end
`else
            checks++;
            if (O_ld_valid !== 1'b1 || O_ld_data !== 64'd0 || O_ld_err !== 1'b1 || O_ld_rd !== 5'd17) begin
                errors++;
                $display("FAIL cross%0d_err: got v=%b data=%h err=%b rd=%0d expected v=1 data=0 err=1 rd=17 (exp if enabled %h)",
                         i, O_ld_valid, O_ld_data, O_ld_err, O_ld_rd, exp);
            end
`endif
            consume();
            checks++;
            if (O_req_ready !== 1'b1) begin errors++; $display("FAIL cross%0d_done: got ready=%b expected 1", i, O_req_ready); end
        end
    endtask

    task automatic test_hold();
        issue_req(3'd0, 2'd3, 1'b1, 5'd9);
        send_beat(64'h8000000000000001);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (O_ld_valid !== 1'b1 || O_ld_data !== 64'h8000000000000001 || O_ld_rd !== 5'd9 || O_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_c%0d: got v=%b data=%h rd=%0d ready=%b expected v=1 data=8000000000000001 rd=9 ready=0",
                         c, O_ld_valid, O_ld_data, O_ld_rd, O_req_ready);
            end
            if (c < 3) tick();
        end
        // A request offered on the completing edge must be refused.
        I_req_valid = 1'b1;
        consume();
        I_req_valid = 1'b0;
        checks++;
        if (O_ld_valid !== 1'b0 || O_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got valid=%b ready=%b expected 0/1", O_ld_valid, O_req_ready);
        end
    endtask

    task automatic test_back_to_back();
        issue_req(3'd7, 2'd0, 1'b1, 5'd1);
        send_beat(C_BEAT1);
        checks++;
        if (O_ld_valid !== 1'b1 || O_ld_data !== 64'h0000000000000011) begin
            errors++;
            $display("FAIL b2b_first: got v=%b data=%h expected v=1 data=0000000000000011", O_ld_valid, O_ld_data);
        end
        consume();
        issue_req(3'd4, 2'd1, 1'b0, 5'd2);
        send_beat(C_BEAT1);
        checks++;
        if (O_ld_valid !== 1'b1 || O_ld_data !== 64'h0000000000003344 || O_ld_rd !== 5'd2) begin
            errors++;
            $display("FAIL b2b_second: got v=%b data=%h rd=%0d expected v=1 data=0000000000003344 rd=2",
                     O_ld_valid, O_ld_data, O_ld_rd);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        issue_req(3'd0, 2'd3, 1'b0, 5'd30);
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        send_beat(C_BEAT0);
        checks++;
        if (O_ld_valid !== 1'b0 || O_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: got valid=%b ready=%b expected 0/1", O_ld_valid, O_req_ready);
        end
        tick();
        checks++;
        if (O_ld_valid !== 1'b0 || O_ld_data !== 64'd0 || O_ld_rd !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got valid=%b data=%h rd=%0d expected 0/0/0", O_ld_valid, O_ld_data, O_ld_rd);
        end
    endtask

    initial begin
        test_reset();
        test_extract();
        test_ignore_idle_beat();
        test_crossing();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_040750_data_ld.md
YSYX_040750_DATA_LD -- requirements
Module: ysyx_040750_data_ld

Interface
REQ-001 SHALL have ports: I_sys_clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: I_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: I_req_valid  in  1  load request valid; O_req_ready  out  1  request accepted when both high.
REQ-004 SHALL have ports: I_addr_off  in  3  byte offset of load address in 8-byte word; I_size  in  2  0=byte,1=half,2=word,3=dword; I_unsigned  in  1  1=zero-extend, 0=sign-extend; I_rd  in  5  destination tag.
REQ-005 SHALL have ports: I_rdata_valid  in  1  memory read beat valid (no backpressure); I_rdata  in  64  8-byte-aligned read beat, little-endian.
REQ-006 SHALL have ports: O_ld_valid  out  1  result valid; I_ld_ready  in  1  consumer ready; O_ld_data  out  64  extended load result; O_ld_rd  out  5  tag of result; O_ld_err  out  1  misaligned-crossing error.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT0, WAIT1, OUT.
REQ-008 O_req_ready SHALL be 1 only in IDLE; a handshake in IDLE registers off/size/unsigned/rd and moves to WAIT0.
REQ-009 Crossing SHALL be defined as off + 2^size > 8 (size 3 with off 0 never crosses).
REQ-010 In WAIT0 on I_rdata_valid: non-crossing -> extract bytes [off, off+2^size) of beat, extend per I_unsigned to 64 bits, register into O_ld_data, go OUT.
REQ-011 I_rdata_valid SHALL be ignored in IDLE and OUT; no beat in WAIT0/WAIT1 keeps state.
REQ-012 Latency: result SHALL appear (O_ld_valid=1) exactly one cycle after the final required beat.
REQ-013 In OUT, O_ld_valid=1 and O_ld_data/O_ld_rd/O_ld_err SHALL hold stable until I_ld_ready=1; on that edge go IDLE.
REQ-014 A new request SHALL NOT be accepted in the same cycle as OUT completes (one idle cycle minimum between results).
REQ-015 Size 3 (dword) SHALL pass data unmodified regardless of I_unsigned.

Reset
REQ-016 On I_rst=1 at a rising edge: state=IDLE, O_ld_valid=0, O_ld_err=0, O_ld_data=0, O_ld_rd=0, captured request cleared; O_req_ready=1 the following cycle.
REQ-017 Reset in WAIT0/WAIT1/OUT SHALL abandon the operation; the pending result is never presented.

Configuration
REQ-018 Macro YSYX_040750_LD_MISALIGN_EN defined: crossing load in WAIT0 stores beat as low half, goes WAIT1; next beat forms {beat1,beat0} 128-bit, shifted right by off*8, extracted/extended, go OUT; O_ld_err constant 0.
REQ-019 Macro undefined: WAIT1 unreachable; crossing load on first beat goes OUT with O_ld_data=0, O_ld_err=1; non-crossing behaviour identical.

Verification
REQ-020 off=3,size=0,signed, beat 0x0123456789ABCDEF -> O_ld_data=0xFFFFFFFFFFFFFF89; same unsigned -> 0x0000000000000089.
REQ-021 off=4,size=2,signed, same beat -> 0x0000000001234567; off=6,size=1,unsigned -> 0x0000000000000123.
REQ-022 off=6,size=2,signed, beats 0x0123456789ABCDEF then 0x1122334455667788 -> with macro 0x0000000077880123, O_ld_err=0, valid one cycle after 2nd beat; without macro -> data 0, O_ld_err=1 after 1st beat.
REQ-023 off=0,size=3, beat 0x8000000000000001, I_ld_ready low 3 cycles -> O_ld_valid and data 0x8000000000000001 held stable 4 cycles, IDLE after ready.
REQ-024 Request accepted, I_rst asserted in WAIT0, beat arrives after reset -> O_ld_valid stays 0, O_req_ready=1.
